// File: rtl/seg_decoder_rx.sv
// seg_decoder_rx: receives an asynchronous 7-segment bus, waits until the
// pattern has been stable for STABLE_CYCLES samples, decodes it to a display
// digit 1..8 (or an error), and offers each new result over a valid/ready port.
module seg_decoder_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic [7:0] out_onehot,
    output logic       out_err,
    output logic       overrun,
    output logic [7:0] err_cnt
);

    // FSM encoding
    localparam logic [1:0] SETTLE = 2'd0;
    localparam logic [1:0] EMIT   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    // The counter saturates at STABLE_CYCLES; a pattern is qualified once the
    // count of consecutive equal comparisons reaches STABLE_CYCLES-1.
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] QUAL_AT = 4'(STABLE_CYCLES - 1);

    logic [6:0] sync1_q, sync1_d;
    logic [6:0] s_q, s_d;
    logic [6:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d;
    logic [6:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic [7:0] onehot_q, onehot_d;
    logic       err_q, err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       same;
    logic       qual;
    logic [3:0] dec_digit;
    logic [7:0] dec_onehot;
    logic       dec_err;

    // Two-flop synchroniser, then a one-cycle-delayed copy for change detection
    always_comb begin
        sync1_d = seg_in;
        s_d     = sync1_q;
        prev_d  = s_q;
    end

    // Stability counter: restart on any change, otherwise count up to CNT_MAX
    always_comb begin
        same = (s_q == prev_q);
        qual = same && (cnt_q >= QUAL_AT);
        if (!same) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Pattern decode of the synchronised value; anything outside the table is an error
    always_comb begin
        dec_digit = 4'd0;
        case (s_q)
            7'h06:   dec_digit = 4'd1;
            7'h5B:   dec_digit = 4'd2;
            7'h4F:   dec_digit = 4'd3;
            7'h66:   dec_digit = 4'd4;
            7'h6D:   dec_digit = 4'd5;
            7'h7D:   dec_digit = 4'd6;
            7'h07:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            default: dec_digit = 4'd0;
        endcase
        dec_err = (dec_digit == 4'd0);
    end

    // One-hot source index: digit N lights bit N-1; an error leaves all bits clear
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign dec_onehot[gi] = (dec_digit == 4'(gi + 1));
        end
    endgenerate

    // Main FSM: qualify, emit once per new pattern, then wait for the bus to move
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        valid_d   = valid_q;
        digit_d   = digit_q;
        onehot_d  = onehot_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            SETTLE: begin
                if (qual && (s_q == 7'h00)) begin
                    // A settled blank forgets the last pattern so it can repeat
                    last_d = 7'h00;
                end else if (qual && en && (s_q != last_q)) begin
                    state_d  = EMIT;
                    last_d   = s_q;
                    valid_d  = 1'b1;
                    digit_d  = dec_digit;
                    onehot_d = dec_onehot;
                    err_d    = dec_err;
                    if (dec_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            EMIT: begin
                // A new settled pattern while the result is still pending is
                // dropped; adopting it as last-accepted keeps it from being
                // emitted later once the consumer catches up.
                if (qual && (s_q != last_q)) begin
                    overrun_d = 1'b1;
                    last_d    = s_q;
                end
                if (out_ready) begin
                    state_d = HOLD;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (s_q != last_q) begin
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = SETTLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 7'h00;
            s_q       <= 7'h00;
            prev_q    <= 7'h00;
            cnt_q     <= 4'd0;
            state_q   <= SETTLE;
            last_q    <= 7'h00;
            valid_q   <= 1'b0;
            digit_q   <= 4'd0;
            onehot_q  <= 8'h00;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            digit_q   <= digit_d;
            onehot_q  <= onehot_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_digit  = digit_q;
    assign out_onehot = onehot_q;
    assign out_err    = err_q;
    assign overrun    = overrun_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg_decoder_rx.sv
// Testbench for seg_decoder_rx: directed scenarios plus randomized pattern
// segments; expected results are queued by a pattern-level model and a
// separate monitor compares them at every completed transfer.
module tb_seg_decoder_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic [7:0] out_onehot;
    logic       out_err;
    logic       overrun;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    seg_decoder_rx #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seg_in     (seg_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digit  (out_digit),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .overrun    (overrun),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [7:0] oh;
        logic       e;
    } res_t;

    res_t expq[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   xfer_cnt = 0;

    logic [6:0] model_last;
    int         model_err;
    logic [6:0] pats [8] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Digit N is the N-th entry of the display table; anything else is an error
    function automatic res_t ref_decode(input logic [6:0] v);
        res_t r;
        r.d  = 4'd0;
        r.oh = 8'h00;
        r.e  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (pats[i] == v) begin
                r.d  = 4'(i + 1);
                r.oh = 8'h01 << i;
                r.e  = 1'b0;
            end
        end
        return r;
    endfunction

    // Pattern-level model: a long, settled segment either clears the memory
    // (blank) or produces one result if it differs from the remembered pattern.
    task automatic model_seg(input logic [6:0] v);
        res_t r;
        if (v == 7'h00) begin
            model_last = 7'h00;
        end else if (v != model_last) begin
            r = ref_decode(v);
            expq.push_back(r);
            if (r.e && model_err < 255) model_err++;
            model_last = v;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        seg_in = v;
        tick(n);
    endtask

    task automatic long_seg(input logic [6:0] v);
        model_seg(v);
        hold(v, 12);
    endtask

    // Count edges until out_valid is seen, bounded
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_last = 7'h00;
        model_err  = 0;
        expq.delete();
    endtask

    // Monitor: compare every completed transfer against the head of the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            res_t e;
            xfer_cnt++;
            if (expq.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_result: got digit %0d err %0b, required no result", out_digit, out_err);
            end else begin
                e = expq.pop_front();
                check("xfer_digit", 32'(out_digit), 32'(e.d));
                check("xfer_onehot", 32'(out_onehot), 32'(e.oh));
                check("xfer_err", 32'(out_err), 32'(e.e));
                $display("xfer %0d: digit=%0d onehot=%02h err=%0b", xfer_cnt, out_digit, out_onehot, out_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int x;
        logic [6:0] v;
        logic [6:0] prev_drv;

        rst = 1'b1; en = 1'b1; out_ready = 1'b1; seg_in = 7'h00;
        model_last = 7'h00; model_err = 0;
        tick(3);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_digit", 32'(out_digit), 0);
        check("rst_onehot", 32'(out_onehot), 0);
        check("rst_err", 32'(out_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        tick(2);

        // Latency and single-cycle pulse for 0x4F
        model_seg(7'h4F);
        seg_in = 7'h4F;
        wait_valid(n);
        check("latency_4f", n, 7);
        check("digit_4f", 32'(out_digit), 3);
        check("onehot_4f", 32'(out_onehot), 32'h04);
        tick(1);
        check("pulse_4f", 32'(out_valid), 0);
        tick(6);

        // Fast toggling never qualifies; holding afterwards gives one result
        long_seg(7'h00);
        x = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            hold(7'h06, 2);
            hold(7'h5B, 2);
        end
        check("toggle_quiet", xfer_cnt, x);
        long_seg(7'h5B);
        check("toggle_then_one", xfer_cnt, x + 1);

        // Blank between repeats re-emits; without it only one result
        long_seg(7'h00);
        x = xfer_cnt;
        long_seg(7'h6D);
        long_seg(7'h00);
        long_seg(7'h6D);
        check("repeat_with_blank", xfer_cnt, x + 2);
        long_seg(7'h00);
        x = xfer_cnt;
        long_seg(7'h6D);
        long_seg(7'h6D);
        check("repeat_no_blank", xfer_cnt, x + 1);

        // Overrun: change while a result waits for the consumer
        long_seg(7'h00);
        x = xfer_cnt;
        out_ready = 1'b0;
        model_seg(7'h7F);
        hold(7'h7F, 20);
        check("ovr_valid_pending", 32'(out_valid), 1);
        check("ovr_digit_pending", 32'(out_digit), 8);
        check("ovr_flag_before", 32'(overrun), 0);
        hold(7'h66, 10);
        check("ovr_valid_held", 32'(out_valid), 1);
        check("ovr_digit_held", 32'(out_digit), 8);
        check("ovr_flag", 32'(overrun), 1);
        model_last = 7'h66;  // the discarded pattern is never offered later
        out_ready = 1'b1;
        hold(7'h66, 15);
        check("ovr_one_xfer", xfer_cnt, x + 1);
        check("ovr_sticky", 32'(overrun), 1);
        long_seg(7'h00);

        // en=0 blocks new captures until it rises again
        x = xfer_cnt;
        en = 1'b0;
        hold(7'h07, 15);
        check("en_blocks", xfer_cnt, x);
        model_seg(7'h07);
        en = 1'b1;
        tick(5);
        check("en_release", xfer_cnt, x + 1);
        long_seg(7'h00);

        // Reset while a result is pending, then re-emit after release
        out_ready = 1'b0;
        seg_in = 7'h7D;
        wait_valid(n);
        check("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_digit", 32'(out_digit), 0);
        check("mid_rst_onehot", 32'(out_onehot), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        model_last = 7'h00;
        model_err  = 0;
        out_ready  = 1'b1;
        model_seg(7'h7D);
        wait_valid(n);
        check("rst_reemit_latency", n, 7);
        tick(12);

        // Randomized segments: long ones settle, short glitches never do
        prev_drv = seg_in;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do v = 7'($urandom_range(0, 127)); while (v == prev_drv);
                hold(v, int'($urandom_range(1, 2)));
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    v = pats[$urandom_range(0, 7)];
                    2:       v = 7'h00;
                    default: v = 7'($urandom_range(1, 127));
                endcase
                long_seg(v);
            end
            prev_drv = v;
        end
        tick(12);
        check("rand_err_cnt", 32'(err_cnt), 32'(model_err));

        // Error saturation: 256 error results separated by blanks
        do_reset();
        for (int i = 0; i < 256; i++) begin
            long_seg((i % 2 == 1) ? 7'h02 : 7'h01);
            long_seg(7'h00);
            if (i == 2) check("err_cnt_early", 32'(err_cnt), 32'(model_err));
        end
        check("err_cnt_sat", 32'(err_cnt), 255);

        tick(20);
        check("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seg_decoder_rx.md
SEG_DECODER_RX -- requirements
Module: seg_decoder_rx

Interface
REQ-001: Parameter STABLE_CYCLES, default 4 (range 2..15); number of consecutive identical synchronised samples that qualifies a segment pattern.
REQ-002: clk  input  1  sole clock; all flops rising-edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: en  input  1  capture enable; low inhibits new captures.
REQ-005: seg_in  input  7  segment bus, bit0..bit6 = segments 0..6; asynchronous to clk.
REQ-006: out_ready  input  1  consumer ready.
REQ-007: out_valid  output  1  decoded result available.
REQ-008: out_digit  output  4  decoded display digit, 1..8; 0 on error.
REQ-009: out_onehot  output  8  one-hot source index (digit N -> bit N-1); 0 on error.
REQ-010: out_err  output  1  result is an unrecognised pattern.
REQ-011: overrun  output  1  sticky: qualified pattern change while a result was pending.
REQ-012: err_cnt  output  8  count of error results, saturating at 255.

Function
REQ-013: seg_in SHALL pass through a 2-flop synchroniser; all further logic uses only the synchronised value s.
REQ-014: Decode table (s, hex, bit6..bit0) -> digit: 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8; any other non-zero value -> error.
REQ-015: 0x00 (blank) SHALL never produce a result; once qualified, it clears the last-accepted pattern so a repeated digit is emitted again.
REQ-016: Stability counter clears whenever s differs from its previous-cycle value, otherwise increments, saturating at STABLE_CYCLES; s qualifies when the counter reaches STABLE_CYCLES-1.
REQ-017: FSM states SETTLE, EMIT, HOLD; reset state SETTLE.
REQ-018: SETTLE -> EMIT when en=1, s is qualified, non-zero, and differs from the last-accepted pattern; on this transition register s as last-accepted and load out_digit/out_onehot/out_err.
REQ-019: SETTLE: a qualified blank updates last-accepted to 0x00 and the FSM stays in SETTLE.
REQ-020: EMIT: out_valid=1 with out_digit/out_onehot/out_err held constant; on out_valid&out_ready -> HOLD and out_valid=0 on the next edge.
REQ-021: EMIT: if s qualifies to a value other than last-accepted before the handshake, overrun SHALL set and that value SHALL be discarded.
REQ-022: HOLD -> SETTLE on the first cycle s differs from last-accepted; otherwise remain in HOLD.
REQ-023: en=0 SHALL block SETTLE->EMIT only; a pending EMIT SHALL still complete its handshake.
REQ-024: err_cnt SHALL increment by 1 when an error result enters EMIT; it SHALL hold at 255.
REQ-025: Latency: with seg_in held stable and en=1, out_valid SHALL rise STABLE_CYCLES+3 clock edges after the first edge that samples the new seg_in value (7 edges at the default).
REQ-026: Outputs SHALL be registered; no combinational path from seg_in or out_ready to any output.

Reset
REQ-027: While rst=1, on each edge: FSM=SETTLE; out_valid=0; out_digit=0; out_onehot=0; out_err=0; overrun=0; err_cnt=0; last-accepted=0x00; synchroniser and stability counter cleared.
REQ-028: rst asserted during EMIT SHALL drop out_valid on that edge with no transfer; rst takes priority over every other event.

Verification
REQ-029: Hold seg_in=0x4F, out_ready=1 -> out_valid pulses one cycle, 7 edges after the first sampling edge, with out_digit=3, out_onehot=0x04, out_err=0.
REQ-030: Toggle seg_in between 0x06 and 0x5B every 2 cycles for 40 cycles, then hold 0x5B -> no result during toggling; exactly one result, digit=2, afterwards.
REQ-031: Apply seg_in=0x7F with out_ready=0 for 20 cycles, then change seg_in to 0x66 and hold 10 cycles -> out_valid stays high, digit=8, overrun=1; raising out_ready completes the transfer and 0x66 is never emitted.
REQ-032: Apply 0x6D, then 0x00, then 0x6D (each held 10 cycles, out_ready=1) -> two results, each digit=5; with 0x00 omitted, only one result.
REQ-033: Apply 256 alternating error patterns (0x01, 0x02) separated by 0x00 -> every result has out_err=1, out_digit=0, out_onehot=0; err_cnt ends at 255.
REQ-034: Assert rst for 1 cycle while out_valid=1 -> next cycle all outputs 0 and FSM in SETTLE; the same held pattern is re-emitted 7 edges after rst is released.
